// File: rtl/umem_arbiter_if.sv
// rtl/umem_arbiter_if.sv - fetch, data and memory-side signals of the unified memory arbiter
interface umem_arbiter_if #(
  parameter int AW = 12
);
  // Instruction-fetch port (read-only)
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [63:0]   if_rdata;
  logic          if_err;

  // Load/store data port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic [7:0]    d_wstrb;
  logic          d_ack;
  logic [63:0]   d_rdata;
  logic          d_err;

  // Single-port block RAM side
  logic          mem_en;
  logic          mem_we;
  logic [7:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [63:0]   mem_wdata;
  logic [63:0]   mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  // Requester and memory view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/umem_arbiter.sv
// rtl/umem_arbiter.sv - data-over-fetch arbiter for the single-port 64-bit unified memory
module umem_arbiter #(
  parameter int DEPTH      = 3000,
  parameter int AW         = 12,
  parameter int MAX_STREAK = 4
) (
  input logic           CLOCK_50,
  input logic           KEY0,
  umem_arbiter_if.slave bus
);

  localparam int SW = $clog2(MAX_STREAK + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t        state;
  state_t        state_nx;

  // Grant decision, valid only while idle
  logic          grant;
  logic          grant_d;
  logic [AW-1:0] grant_addr;
  logic          grant_oor;

  // Captured transaction
  logic          owner_d;
  logic          cap_we;
  logic          err_q;
  logic [SW-1:0] streak;

  logic [63:0]   if_rdata_q;
  logic [63:0]   d_rdata_q;
  logic [7:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [63:0]   mem_wdata_q;

  // State register
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Arbitration and next-state; fetch wins a tie only once data has hit its streak limit
  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_d    = 1'b0;
    grant_addr = bus.if_addr;
    grant_oor  = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.d_req || bus.if_req) begin
          grant      = 1'b1;
          grant_d    = bus.d_req && (!bus.if_req || (streak != SW'(MAX_STREAK)));
          grant_addr = grant_d ? bus.d_addr : bus.if_addr;
          grant_oor  = ({1'b0, grant_addr} >= (AW + 1)'(DEPTH));
          state_nx   = grant_oor ? S_ACK : S_ISSUE;
        end
      end
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT:  state_nx = S_ACK;
      S_ACK:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Grant capture, streak tracking and read-data return
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      owner_d     <= 1'b0;
      cap_we      <= 1'b0;
      err_q       <= 1'b0;
      streak      <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (grant) begin
        owner_d <= grant_d;
        cap_we  <= grant_d && bus.d_we;
        err_q   <= grant_oor;
        // Out-of-range grants never reach the memory, so its bus keeps the last issued values
        if (!grant_oor) begin
          mem_addr_q <= grant_addr;
          mem_be_q   <= (grant_d && bus.d_we) ? bus.d_wstrb : 8'hFF;
          if (grant_d) begin
            mem_wdata_q <= bus.d_wdata;
          end
        end
        if (grant_d && bus.if_req) begin
          if (streak != SW'(MAX_STREAK)) begin
            streak <= streak + SW'(1);
          end
        end else begin
          streak <= '0;
        end
      end
      // Memory data is valid during WAIT; write accesses leave both read registers alone
      if (state == S_WAIT && !cap_we) begin
        if (owner_d) begin
          d_rdata_q <= bus.mem_rdata;
        end else begin
          if_rdata_q <= bus.mem_rdata;
        end
      end
    end
  end

  assign bus.if_ack    = (state == S_ACK) && !owner_d;
  assign bus.d_ack     = (state == S_ACK) && owner_d;
  assign bus.if_err    = bus.if_ack && err_q;
  assign bus.d_err     = bus.d_ack && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

  assign bus.mem_en    = (state == S_ISSUE);
  assign bus.mem_we    = (state == S_ISSUE) && owner_d && cap_we;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_umem_arbiter.sv
// tb/tb_umem_arbiter.sv - directed self-checking bench for umem_arbiter
module tb_umem_arbiter;

  localparam logic [63:0] M5  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] M7  = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] M20 = 64'h2020_2020_A5A5_0020;
  localparam logic [63:0] M21 = 64'h2121_2121_5A5A_0021;

  logic clk = 1'b0;
  logic key0;
  always #10 clk = ~clk;

  umem_arbiter_if #(.AW(12)) bus ();

  umem_arbiter #(.DEPTH(3000), .AW(12), .MAX_STREAK(4)) dut (
    .CLOCK_50(clk),
    .KEY0    (key0),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Block-RAM model with 1-cycle read and a back-door preload port
  logic [63:0] mem [0:2999];
  logic        pl_en;
  logic [11:0] pl_addr;
  logic [63:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_en && bus.mem_addr < 12'd3000) begin
      bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.mem_we) begin
        for (int b = 0; b < 8; b++) begin
          if (bus.mem_be[b]) mem[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
        end
      end
    end
  end

  // Results of the last run_req call
  int          ack_cyc;
  int          en_cnt;
  int          en_cyc;
  bit          err;
  logic        s_we;
  logic [7:0]  s_be;
  logic [11:0] s_addr;
  logic [63:0] s_wdata;
  logic [63:0] exp_d_rdata;
  logic [63:0] exp_if_rdata;

  task automatic preload(input logic [11:0] a, input logic [63:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(posedge clk); #1;
    pl_en   = 1'b0;
  endtask

  // Issue one request from a cycle boundary; cycle 0 is the cycle the request is first seen
  task automatic run_req(input bit is_d, input bit we, input logic [11:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
    ack_cyc = -1; err = 1'b0; en_cnt = 0; en_cyc = -1;
    s_we = 1'b0; s_be = '0; s_addr = '0; s_wdata = '0;
    if (is_d) begin
      bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_wstrb = wstrb; bus.d_req = 1'b1;
    end else begin
      bus.if_addr = addr; bus.if_req = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_en) begin
        en_cnt++; en_cyc = c;
        s_we = bus.mem_we; s_be = bus.mem_be; s_addr = bus.mem_addr; s_wdata = bus.mem_wdata;
      end
      if (is_d ? bus.d_ack : bus.if_ack) begin
        ack_cyc = c;
        err = is_d ? bus.d_err : bus.if_err;
        break;
      end
      // Changing the request fields after the grant must have no effect
      if (c == 1) begin
        bus.d_addr = addr + 12'd1; bus.d_wdata = ~wdata; bus.d_wstrb = ~wstrb;
        bus.if_addr = addr + 12'd1;
      end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.if_req = 1'b0;
  endtask

  task automatic test_reset();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'd7; bus.if_req = 1'b1; bus.if_addr = 12'd5;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    vectors++; if ({bus.if_ack, bus.d_ack, bus.if_err, bus.d_err} !== 4'b0) begin miscompares++; $display("FAIL reset_acks: got %b expected 0000", {bus.if_ack, bus.d_ack, bus.if_err, bus.d_err}); end
    vectors++; if (bus.if_rdata !== 64'd0 || bus.d_rdata !== 64'd0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.d_rdata); end
    vectors++; if ({bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr} !== 22'd0 || bus.mem_wdata !== 64'd0) begin miscompares++; $display("FAIL reset_mem: got en=%b we=%b be=%h addr=%h wdata=%h expected all 0", bus.mem_en, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata); end
    @(posedge clk); #1;
    key0 = 1'b1; bus.if_req = 1'b0;
    run_req(1'b1, 1'b0, 12'd7, 64'd0, 8'h00);
    vectors++; if (en_cyc !== 1 || s_addr !== 12'd7) begin miscompares++; $display("FAIL reset_first_grant: got en_cyc=%0d addr=%0d expected 1/7", en_cyc, s_addr); end
    vectors++; if (ack_cyc !== 3 || bus.d_rdata !== M7) begin miscompares++; $display("FAIL reset_first_read: got ack=%0d rdata=%h expected 3/%h", ack_cyc, bus.d_rdata, M7); end
    exp_d_rdata = M7;
  endtask

  task automatic test_single_fetch();
    run_req(1'b0, 1'b0, 12'd5, 64'd0, 8'h00);
    vectors++; if (en_cyc !== 1 || en_cnt !== 1 || s_addr !== 12'd5) begin miscompares++; $display("FAIL fetch_issue: got en_cyc=%0d cnt=%0d addr=%0d expected 1/1/5", en_cyc, en_cnt, s_addr); end
    vectors++; if (s_we !== 1'b0 || s_be !== 8'hFF) begin miscompares++; $display("FAIL fetch_we_be: got we=%b be=%h expected 0/ff", s_we, s_be); end
    vectors++; if (ack_cyc !== 3 || err !== 1'b0) begin miscompares++; $display("FAIL fetch_ack: got cyc=%0d err=%b expected 3/0", ack_cyc, err); end
    vectors++; if (bus.if_rdata !== M5) begin miscompares++; $display("FAIL fetch_rdata: got %h expected %h", bus.if_rdata, M5); end
    vectors++; if (bus.d_rdata !== exp_d_rdata) begin miscompares++; $display("FAIL fetch_d_rdata_hold: got %h expected %h", bus.d_rdata, exp_d_rdata); end
    exp_if_rdata = M5;
  endtask

  task automatic test_write_read();
    run_req(1'b1, 1'b1, 12'd10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    vectors++; if (s_we !== 1'b1 || s_be !== 8'h0F || s_addr !== 12'd10 || s_wdata !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL write_issue: got we=%b be=%h addr=%0d wdata=%h expected 1/0f/10/ffffffffffffffff", s_we, s_be, s_addr, s_wdata); end
    vectors++; if (ack_cyc !== 3 || err !== 1'b0) begin miscompares++; $display("FAIL write_ack: got cyc=%0d err=%b expected 3/0", ack_cyc, err); end
    vectors++; if (bus.d_rdata !== exp_d_rdata) begin miscompares++; $display("FAIL write_d_rdata_hold: got %h expected %h", bus.d_rdata, exp_d_rdata); end
    run_req(1'b1, 1'b0, 12'd10, 64'd0, 8'h00);
    vectors++; if (ack_cyc !== 3 || s_be !== 8'hFF || bus.d_rdata !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL readback: got cyc=%0d be=%h rdata=%h expected 3/ff/00000000ffffffff", ack_cyc, s_be, bus.d_rdata); end
    exp_d_rdata = 64'h0000_0000_FFFF_FFFF;
  endtask

  task automatic test_zero_strobe();
    run_req(1'b1, 1'b1, 12'd10, 64'd0, 8'h00);
    vectors++; if (en_cnt !== 1 || s_we !== 1'b1 || s_be !== 8'h00) begin miscompares++; $display("FAIL zero_strobe_issue: got cnt=%0d we=%b be=%h expected 1/1/00", en_cnt, s_we, s_be); end
    vectors++; if (ack_cyc !== 3 || err !== 1'b0) begin miscompares++; $display("FAIL zero_strobe_ack: got cyc=%0d err=%b expected 3/0", ack_cyc, err); end
    run_req(1'b1, 1'b0, 12'd10, 64'd0, 8'h00);
    vectors++; if (bus.d_rdata !== 64'h0000_0000_FFFF_FFFF) begin miscompares++; $display("FAIL zero_strobe_readback: got %h expected 00000000ffffffff", bus.d_rdata); end
  endtask

  task automatic test_out_of_range();
    run_req(1'b1, 1'b0, 12'd3000, 64'd0, 8'h00);
    vectors++; if (ack_cyc !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL oor_data_ack: got cyc=%0d err=%b expected 1/1", ack_cyc, err); end
    vectors++; if (en_cnt !== 0 || bus.d_rdata !== exp_d_rdata) begin miscompares++; $display("FAIL oor_data_side: got en_cnt=%0d rdata=%h expected 0/%h", en_cnt, bus.d_rdata, exp_d_rdata); end
    run_req(1'b0, 1'b0, 12'd4095, 64'd0, 8'h00);
    vectors++; if (ack_cyc !== 1 || err !== 1'b1) begin miscompares++; $display("FAIL oor_fetch_ack: got cyc=%0d err=%b expected 1/1", ack_cyc, err); end
    vectors++; if (en_cnt !== 0 || bus.if_rdata !== exp_if_rdata) begin miscompares++; $display("FAIL oor_fetch_side: got en_cnt=%0d rdata=%h expected 0/%h", en_cnt, bus.if_rdata, exp_if_rdata); end
    vectors++; if (bus.mem_addr !== 12'd10) begin miscompares++; $display("FAIL oor_mem_addr_hold: got %0d expected 10", bus.mem_addr); end
  endtask

  task automatic test_contention();
    string seq = "";
    int    got = 0;
    int    both = 0;
    bus.d_we = 1'b0; bus.d_addr = 12'd20; bus.if_addr = 12'd21;
    bus.d_req = 1'b1; bus.if_req = 1'b1;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge clk);
      if (bus.d_ack && bus.if_ack) both++;
      if (bus.d_ack) begin seq = {seq, "D"}; got++; end
      if (bus.if_ack) begin seq = {seq, "I"}; got++; end
    end
    @(posedge clk); #1;
    bus.d_req = 1'b0; bus.if_req = 1'b0;
    vectors++; if (seq != "DDDDIDDDDI") begin miscompares++; $display("FAIL contention_order: got '%s' expected 'DDDDIDDDDI'", seq); end
    vectors++; if (both !== 0) begin miscompares++; $display("FAIL contention_dual_ack: got %0d expected 0", both); end
    vectors++; if (bus.d_rdata !== M20 || bus.if_rdata !== M21) begin miscompares++; $display("FAIL contention_rdata: got %h/%h expected %h/%h", bus.d_rdata, bus.if_rdata, M20, M21); end
  endtask

  task automatic test_mid_reset();
    int acks = 0;
    bus.if_addr = 12'd5; bus.if_req = 1'b1;
    repeat (3) @(negedge clk);
    key0 = 1'b0; bus.if_req = 1'b0;
    @(negedge clk);
    if (bus.if_ack || bus.d_ack) acks++;
    vectors++; if (bus.if_rdata !== 64'd0 || bus.d_rdata !== 64'd0) begin miscompares++; $display("FAIL midreset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.d_rdata); end
    @(posedge clk); #1;
    key0 = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.if_ack || bus.d_ack || bus.mem_en) acks++;
    end
    vectors++; if (acks !== 0) begin miscompares++; $display("FAIL midreset_no_ack: got %0d activity cycles expected 0", acks); end
    @(posedge clk); #1;
    run_req(1'b0, 1'b0, 12'd5, 64'd0, 8'h00);
    vectors++; if (ack_cyc !== 3 || err !== 1'b0 || bus.if_rdata !== M5) begin miscompares++; $display("FAIL midreset_retry: got cyc=%0d err=%b rdata=%h expected 3/0/%h", ack_cyc, err, bus.if_rdata, M5); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t reached, required summary before it", $time);
    $fatal(1);
  end

  initial begin
    key0 = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;
    exp_d_rdata = '0; exp_if_rdata = '0;
    preload(12'd5, M5);
    preload(12'd7, M7);
    preload(12'd10, 64'd0);
    preload(12'd20, M20);
    preload(12'd21, M21);
    test_reset();
    test_single_fetch();
    test_write_read();
    test_zero_strobe();
    test_out_of_range();
    test_contention();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
